// File: rtl/wts_pkg.sv
// wts_pkg: shared state encoding and widths for the wave-table SRAM scheduler.
package wts_pkg;
  localparam int WTS_WAVE_AW = 7;
  localparam int WTS_SAMPLE_W = 8;
  typedef enum logic [2:0] {IDLE, SWEEP, LAST, CPU, CPU_DONE} wts_state_e;
endpackage

// File: rtl/wts_sram_scheduler.sv
// wts_sram_scheduler: time-slots the wave SRAM between channel sample sweeps and CPU accesses.
// Optional WTS_SCHED_OVERRUN_CLR_EN adds an overrun_clr input to clear the sticky overrun flag.
module wts_sram_scheduler import wts_pkg::*; #(
  parameter int NUM_CH = 5,
  parameter int CH_W = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             active,
  input  logic [NUM_CH*WTS_WAVE_AW-1:0]    ch_wave_addr,
  output logic [NUM_CH*WTS_SAMPLE_W-1:0]   ch_sample,
  output logic                             sample_valid,
  output logic [CH_W+WTS_WAVE_AW-1:0]      sram_a,
  output logic                             sram_we,
  output logic [WTS_SAMPLE_W-1:0]          sram_d,
  input  logic [WTS_SAMPLE_W-1:0]          sram_q,
  input  logic                             cpu_req,
  input  logic                             cpu_we,
  input  logic [CH_W+WTS_WAVE_AW-1:0]      cpu_a,
  input  logic [WTS_SAMPLE_W-1:0]          cpu_d,
  output logic [WTS_SAMPLE_W-1:0]          cpu_q,
`ifdef WTS_SCHED_OVERRUN_CLR_EN
  input  logic                             overrun_clr,
`endif
  output logic                             cpu_ack,
  output logic                             overrun
);
  wts_state_e state_q, state_d;
  logic [CH_W-1:0] idx_q, idx_d, cap_idx_q;
  logic [WTS_WAVE_AW-1:0] wa [NUM_CH];
  logic [WTS_SAMPLE_W-1:0] samp_q [NUM_CH];
  logic [WTS_SAMPLE_W-1:0] cpu_q_q;
  logic cap_v_q, pend_q, pend_d, ovr_set, ovr_d, sample_valid_q, overrun_q;
  assign sample_valid = sample_valid_q;
  assign overrun = overrun_q;
  always_comb begin
    state_d = state_q;
    idx_d = '0;
    pend_d = pend_q;
    ovr_set = 1'b0;
    sram_a = '0;
    sram_we = 1'b0;
    sram_d = '0;
    cpu_ack = 1'b0;
    cpu_q = cpu_q_q;
    case (state_q)
      IDLE: state_d = active ? SWEEP : cpu_req ? CPU : IDLE;
      SWEEP: begin
        sram_a = {idx_q, wa[idx_q]};
        ovr_set = active;
        idx_d = active ? '0 : idx_q + 1'b1;
        state_d = (active || idx_q != CH_W'(NUM_CH - 1)) ? SWEEP : LAST;
      end
      LAST: begin
        ovr_set = active;
        state_d = active ? SWEEP : IDLE;
      end
      CPU: begin
        sram_a = cpu_a;
        sram_we = cpu_we;
        sram_d = cpu_d;
        pend_d = pend_q | active;
        state_d = CPU_DONE;
      end
      CPU_DONE: begin
        cpu_ack = 1'b1;
        cpu_q = cpu_we ? cpu_q_q : sram_q;
        pend_d = 1'b0;
        state_d = (pend_q || active) ? SWEEP : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
`ifdef WTS_SCHED_OVERRUN_CLR_EN
  assign ovr_d = ovr_set | (overrun_q & ~overrun_clr);
`else
  assign ovr_d = ovr_set | overrun_q;
`endif
  // Capture lags the address slot by one cycle, so an aborted sweep still lands its last read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      pend_q <= 1'b0;
      cap_v_q <= 1'b0;
      cap_idx_q <= '0;
      sample_valid_q <= 1'b0;
      overrun_q <= 1'b0;
      cpu_q_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      pend_q <= pend_d;
      cap_v_q <= state_q == SWEEP;
      cap_idx_q <= idx_q;
      sample_valid_q <= state_q == LAST && !active;
      overrun_q <= ovr_d;
      cpu_q_q <= cpu_q;
    end
  end
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign wa[k] = ch_wave_addr[k*WTS_WAVE_AW +: WTS_WAVE_AW];
    assign ch_sample[k*WTS_SAMPLE_W +: WTS_SAMPLE_W] = samp_q[k];
    always_ff @(posedge clk or posedge reset) begin
      if (reset) samp_q[k] <= '0;
      else if (cap_v_q && cap_idx_q == CH_W'(k)) samp_q[k] <= sram_q;
    end
  end
endmodule

// File: tb/tb_wts_sram_scheduler.sv
// tb_wts_sram_scheduler: directed bench with an SRAM model and a read-data scoreboard.
module tb_wts_sram_scheduler;
  localparam int NUM_CH = 5;
  localparam int CH_W = 3;
  logic clk = 1'b0, reset = 1'b1, active = 1'b0;
  logic [NUM_CH*7-1:0] ch_wave_addr;
  logic [NUM_CH*8-1:0] ch_sample;
  logic sample_valid, sram_we, cpu_req = 1'b0, cpu_we = 1'b0, cpu_ack, overrun;
  logic [CH_W+6:0] sram_a, cpu_a = '0;
  logic [7:0] sram_d, sram_q, cpu_d = '0, cpu_q;
`ifdef WTS_SCHED_OVERRUN_CLR_EN
  logic overrun_clr = 1'b0;
`endif
  int cyc = 0, sv_cnt = 0, sv_cyc = -1, ack_cnt = 0, we_cnt = 0;
  int tests = 0, fails = 0;
  logic [7:0] mem [1024];
  bit wr [1024];
  logic [7:0] shadow [int];
  logic [7:0] exp_q [$];

  wts_sram_scheduler #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
    .clk(clk), .reset(reset), .active(active), .ch_wave_addr(ch_wave_addr),
    .ch_sample(ch_sample), .sample_valid(sample_valid), .sram_a(sram_a),
    .sram_we(sram_we), .sram_d(sram_d), .sram_q(sram_q), .cpu_req(cpu_req),
    .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_d(cpu_d), .cpu_q(cpu_q),
`ifdef WTS_SCHED_OVERRUN_CLR_EN
    .overrun_clr(overrun_clr),
`endif
    .cpu_ack(cpu_ack), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Untouched SRAM words read back as their low 7 address bits (the wave address).
  always @(posedge clk) begin
    if (sram_we) begin
      mem[sram_a] <= sram_d;
      wr[sram_a] <= 1'b1;
    end
    sram_q <= wr[sram_a] ? mem[sram_a] : {1'b0, sram_a[6:0]};
  end

  always @(negedge clk) begin
    if (sample_valid) begin
      sv_cnt++;
      sv_cyc = cyc;
    end
    if (cpu_ack) ack_cnt++;
    if (sram_we) we_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] exp_rd(input logic [9:0] a);
    return shadow.exists(int'(a)) ? shadow[int'(a)] : {1'b0, a[6:0]};
  endfunction

  // act_at: cycle offset from request at which to pulse active (-1 = none).
  task automatic cpu_access(input string tag, input logic we, input logic [9:0] a,
                            input logic [7:0] d, input int act_at, input int exp_lat,
                            output int ack_t);
    int t0;
    bit got;
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_a = a;
    cpu_d = d;
    t0 = cyc;
    if (we) shadow[int'(a)] = d;
    else exp_q.push_back(exp_rd(a));
    active = act_at == 0;
    got = 0;
    ack_t = -1;
    for (int n = 0; n < 20 && !got; n++) begin
      @(posedge clk);
      #1;
      active = act_at == n + 1;
      @(negedge clk);
      got = cpu_ack;
    end
    if (got) begin
      ack_t = cyc;
      chk({tag, "_lat"}, 64'(ack_t - t0), 64'(exp_lat));
      if (!we) chk({tag, "_q"}, 64'(cpu_q), 64'(exp_q.pop_front()));
    end else begin
      chk({tag, "_ack_timeout"}, 64'(0), 64'(1));
      if (!we) void'(exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    active = 1'b0;
  endtask

  initial begin
    int t, b, w, ack_t;
    for (int k = 0; k < NUM_CH; k++) ch_wave_addr[k*7 +: 7] = 7'(k * 3);
    step(2);
    chk("rst_sram_a", 64'(sram_a), 64'(0));
    chk("rst_sram_we", 64'(sram_we), 64'(0));
    chk("rst_ch_sample", 64'(ch_sample), 64'(0));
    chk("rst_cpu_q", 64'(cpu_q), 64'(0));
    chk("rst_flags", 64'({cpu_ack, sample_valid, overrun}), 64'(0));
    reset = 1'b0;
    step(2);

    t = cyc;
    b = sv_cnt;
    w = we_cnt;
    active = 1'b1;
    step(1);
    active = 1'b0;
    step(10);
    chk("sweep_samples", 64'(ch_sample), 64'({8'd12, 8'd9, 8'd6, 8'd3, 8'd0}));
    chk("sweep_sv_cnt", 64'(sv_cnt - b), 64'(1));
    chk("sweep_sv_cyc", 64'(sv_cyc - t), 64'(7));
    chk("sweep_no_we", 64'(we_cnt - w), 64'(0));

    w = we_cnt;
    cpu_access("wr", 1'b1, 10'h085, 8'hA5, -1, 2, ack_t);
    chk("wr_we_once", 64'(we_cnt - w), 64'(1));
    w = we_cnt;
    cpu_access("rd", 1'b0, 10'h085, 8'h00, -1, 2, ack_t);
    chk("rd_no_we", 64'(we_cnt - w), 64'(0));
    step(2);

    t = cyc;
    b = sv_cnt;
    cpu_access("cont", 1'b0, 10'h085, 8'h00, 0, NUM_CH + 4, ack_t);
    chk("cont_sv_cyc", 64'(sv_cyc - t), 64'(7));
    chk("cont_sv_cnt", 64'(sv_cnt - b), 64'(1));
    step(2);

    b = sv_cnt;
    cpu_access("pend", 1'b0, 10'h2ff, 8'h00, 1, 2, ack_t);
    step(8);
    chk("pend_sv_cnt", 64'(sv_cnt - b), 64'(1));
    chk("pend_sv_cyc", 64'(sv_cyc - ack_t), 64'(7));
    chk("pre_overrun", 64'(overrun), 64'(0));

    t = cyc;
    b = sv_cnt;
    active = 1'b1;
    step(1);
    active = 1'b0;
    step(2);
    active = 1'b1;
    step(1);
    active = 1'b0;
    step(1);
    @(negedge clk);
    chk("ovr_restart_a", 64'(sram_a), 64'(10'h083));
    step(8);
    chk("ovr_flag", 64'(overrun), 64'(1));
    chk("ovr_sv_cnt", 64'(sv_cnt - b), 64'(1));
    chk("ovr_sv_cyc", 64'(sv_cyc - t), 64'(10));
`ifdef WTS_SCHED_OVERRUN_CLR_EN
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;
    chk("ovr_clr", 64'(overrun), 64'(0));
`else
    step(3);
    chk("ovr_sticky", 64'(overrun), 64'(1));
`endif

    b = ack_cnt;
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_a = 10'h085;
    step(1);
    reset = 1'b1;
    #1;
    cpu_req = 1'b0;
    step(3);
    chk("rstcpu_no_ack", 64'(ack_cnt - b), 64'(0));
    chk("rstcpu_outs", 64'({ch_sample, cpu_q, sample_valid, overrun}), 64'(0));
    chk("rstcpu_sram_a", 64'(sram_a), 64'(0));
    reset = 1'b0;
    step(2);
    cpu_access("post_rst", 1'b0, 10'h085, 8'h00, -1, 2, ack_t);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
